// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and the single-cycle
// ALU function for the registered ALU core.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_ADDS = 4'b1011;
    localparam logic [3:0] OP_SUBS = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1101;

    localparam int MAXW  = 64;
    localparam int MAXSH = 6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [MAXW-1:0] res;
        logic            ovf;
        logic            undef;
    } alu_res_t;

    // Operands arrive sign-extended to MAXW; w is the live width.
    function automatic alu_res_t alu_single(
        input logic [3:0]       op,
        input logic [MAXW-1:0]  a,
        input logic [MAXW-1:0]  b,
        input logic [MAXSH-1:0] sh,
        input int unsigned      w
    );
        alu_res_t        r;
        logic [MAXW-1:0] sum;
        logic [MAXW-1:0] dif;
        logic [MAXW-1:0] mask;
        logic [5:0]      msb;
        r    = '0;
        sum  = a + b;
        dif  = a - b;
        mask = {MAXW{1'b1}} >> (MAXW - w);
        msb  = 6'(w - 1);
        case (op)
            OP_AND:  r.res = a & b;
            OP_OR:   r.res = a | b;
            OP_ADD:  r.res = sum;
            OP_XOR:  r.res = a ^ b;
            OP_NOR:  r.res = ~(a | b);
            OP_SUB:  r.res = dif;
            OP_SLT:  r.res[0] = $signed(a) < $signed(b);
            OP_SLL:  r.res = a << sh;
            OP_SRL:  r.res = (a & mask) >> sh;
            OP_SRA:  r.res = $signed(a) >>> sh;
            OP_ADDS: begin
                r.res = sum;
                r.ovf = (a[MAXW-1] == b[MAXW-1]) &&
                        (sum[msb] != a[MAXW-1]);
            end
            OP_SUBS: begin
                r.res = dif;
                r.ovf = (a[MAXW-1] != b[MAXW-1]) &&
                        (dif[msb] != a[MAXW-1]);
            end
            OP_MULU: r.res = '0;
            default: r.undef = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipelined_alu_core_mul.sv
// Iterative shift-add unsigned multiplier, one
// multiplier bit retired per step.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               last,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     sum;

    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        done_d  = done_q;
        // Upper half accumulates; multiplier shifts out of the lower half.
        sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
              (prod_q[0] ? {1'b0, mcand_q} : '0);
        if (start) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            done_d  = 1'b0;
        end else if (step) begin
            prod_d = {sum, prod_q[WIDTH-1:1]};
            if (last) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: rtl/pipelined_alu_core.sv
// Registered ALU with valid/ready on both sides and
// an iterative unsigned multiply.
module pipelined_alu_core
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic               accept, is_mul, load_single, load_mul;
    logic               mul_start, mul_step, mul_last, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [MAXW-1:0]    a_s, b_s;
    logic [MAXSH-1:0]   sh;
    alu_res_t           fr;

    assign a_s = MAXW'($signed(operand0));
    assign b_s = MAXW'($signed(operand1));
    assign sh  = MAXSH'(operand1[SHW-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept && is_mul) state_d = S_MUL;
            end
            S_MUL: begin
                if (load_mul) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (mul_step && !mul_last) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // A finished multiply waits at its last count until the output is free.
    always_comb begin
        in_ready    = rst_n && (state_q == S_IDLE) &&
                      (!out_valid_q || out_ready);
        busy        = (state_q == S_MUL);
        accept      = in_valid && in_ready;
        is_mul      = (control == OP_MULU);
        mul_start   = accept && is_mul;
        mul_step    = busy && !mul_done;
        mul_last    = (cnt_q == SHW'(WIDTH - 1));
        load_single = accept && !is_mul;
        load_mul    = busy && mul_done && mul_last &&
                      (!out_valid_q || out_ready);
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .step  (mul_step),
        .last  (mul_last),
        .a     (operand0),
        .b     (operand1),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        fr          = alu_single(control, a_s, b_s, sh, WIDTH);
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        if (load_single) begin
            out_valid_d = 1'b1;
            result_d    = fr.res[WIDTH-1:0];
            overflow_d  = fr.ovf;
            zero_d      = !fr.undef && (fr.res[WIDTH-1:0] == '0);
        end else if (load_mul) begin
            out_valid_d = 1'b1;
            result_d    = mul_prod[WIDTH-1:0];
            overflow_d  = |mul_prod[2*WIDTH-1:WIDTH];
            zero_d      = (mul_prod[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_alu_core.sv
// Directed bench for pipelined_alu_core, 32-bit and
// 16-bit instances.
module tb_pipelined_alu_core;
    import alu_pkg::*;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        o;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        iv = 1'b0, ir, ov, ordy = 1'b1;
    logic [3:0]  ctl = 4'd0;
    logic [31:0] a = '0, b = '0, res;
    logic        ovf, zr, bsy;

    logic        iv16 = 1'b0, ir16, ov16, ordy16 = 1'b1;
    logic [3:0]  ctl16 = 4'd0;
    logic [15:0] a16 = '0, b16 = '0, res16;
    logic        ovf16, zr16, bsy16;

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pipelined_alu_core #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv), .in_ready(ir),
        .control(ctl), .operand0(a), .operand1(b),
        .out_valid(ov), .out_ready(ordy),
        .result(res), .overflow(ovf), .zero(zr),
        .busy(bsy)
    );

    pipelined_alu_core #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .control(ctl16), .operand0(a16), .operand1(b16),
        .out_valid(ov16), .out_ready(ordy16),
        .result(res16), .overflow(ovf16), .zero(zr16),
        .busy(bsy16)
    );

    task automatic drive(input logic [3:0] op,
                         input logic [31:0] x,
                         input logic [31:0] y);
        ctl = op;
        a   = x;
        b   = y;
        iv  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        nvec++;
        if ({ov, ovf, zr, bsy, ir} !== 5'b0 || res !== 32'h0) begin
            nfail++;
            $display("FAIL reset32: got v%b o%b z%b b%b r%b res=%h exp all 0",
                     ov, ovf, zr, bsy, ir, res);
        end
        nvec++;
        if ({ov16, bsy16, ir16} !== 3'b0 || res16 !== 16'h0) begin
            nfail++;
            $display("FAIL reset16: got v%b b%b r%b res=%h exp all 0",
                     ov16, bsy16, ir16, res16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (ir !== 1'b1) begin
            nfail++;
            $display("FAIL reset_ready: got %b exp 1", ir);
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [13];
        v[0]  = '{OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b1};
        v[1]  = '{OP_ADDS, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0};
        v[2]  = '{OP_SUBS, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0};
        v[3]  = '{OP_SLT,  32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0};
        v[4]  = '{OP_SLT,  32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1};
        v[5]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
        v[6]  = '{OP_OR,   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0};
        v[7]  = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0};
        v[8]  = '{OP_NOR,  32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[9]  = '{OP_SUB,  32'h5, 32'h7, 32'hFFFFFFFE, 1'b0, 1'b0};
        v[10] = '{OP_ADDS, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0};
        v[11] = '{OP_SUBS, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[12] = '{OP_ADD,  32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0};
        ordy = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].a, v[i].b);
            #1;
            nvec++;
            if (ir !== 1'b1) begin
                nfail++;
                $display("FAIL b2b_ready[%0d]: got %b exp 1", i, ir);
            end
            @(posedge clk);
            #1;
            nvec++;
            if (ov !== 1'b1 || res !== v[i].r ||
                ovf !== v[i].o || zr !== v[i].z) begin
                nfail++;
                $display("FAIL b2b[%0d]: got v%b %h o%b z%b exp v1 %h o%b z%b",
                         i, ov, res, ovf, zr, v[i].r, v[i].o, v[i].z);
            end
        end
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic test_shifts();
        vec_t v [7];
        v[0] = '{OP_SRA, 32'h80000000, 32'h21, 32'hC0000000, 1'b0, 1'b0};
        v[1] = '{OP_SRL, 32'h80000000, 32'h4,  32'h08000000, 1'b0, 1'b0};
        v[2] = '{OP_SLL, 32'h1,        32'h1F, 32'h80000000, 1'b0, 1'b0};
        v[3] = '{OP_SRL, 32'h80000000, 32'h24, 32'h08000000, 1'b0, 1'b0};
        v[4] = '{OP_SRA, 32'h40000000, 32'h1,  32'h20000000, 1'b0, 1'b0};
        v[5] = '{OP_SLL, 32'hFFFFFFFF, 32'h20, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[6] = '{OP_SRA, 32'h80000000, 32'h1F, 32'hFFFFFFFF, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].a, v[i].b);
            @(posedge clk);
            #1;
            nvec++;
            if (ov !== 1'b1 || res !== v[i].r || ovf !== 1'b0) begin
                nfail++;
                $display("FAIL shift[%0d]: got v%b %h o%b exp v1 %h o0",
                         i, ov, res, ovf, v[i].r);
            end
        end
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic test_mulu();
        logic [31:0] ma [2];
        logic [31:0] mb [2];
        logic [31:0] mr [2];
        logic        mo [2];
        logic        mz [2];
        int          lat;
        ma[0] = 32'h00010000; mb[0] = 32'h00010000;
        mr[0] = 32'h0; mo[0] = 1'b1; mz[0] = 1'b1;
        ma[1] = 32'd1234; mb[1] = 32'd5678;
        mr[1] = 32'd7006652; mo[1] = 1'b0; mz[1] = 1'b0;
        ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(OP_MULU, ma[i], mb[i]);
            @(posedge clk);
            #1;
            iv = 1'b0;
            a  = 32'hDEADBEEF;
            b  = 32'hFFFFFFFF;
            nvec++;
            if (bsy !== 1'b1 || ir !== 1'b0 || ov !== 1'b0) begin
                nfail++;
                $display("FAIL mul_busy[%0d]: got b%b r%b v%b exp b1 r0 v0",
                         i, bsy, ir, ov);
            end
            lat = 0;
            while (ov !== 1'b1 && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            nvec++;
            if (lat != 33) begin
                nfail++;
                $display("FAIL mul_lat[%0d]: got %0d exp 33", i, lat);
            end
            nvec++;
            if (res !== mr[i] || ovf !== mo[i] || zr !== mz[i] ||
                bsy !== 1'b0) begin
                nfail++;
                $display("FAIL mul[%0d]: got %h o%b z%b b%b exp %h o%b z%b b0",
                         i, res, ovf, zr, bsy, mr[i], mo[i], mz[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        ordy = 1'b0;
        drive(OP_ADD, 32'd10, 32'd20);
        @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b1 || res !== 32'd30) begin
            nfail++;
            $display("FAIL bp_first: got v%b %0d exp v1 30", ov, res);
        end
        @(negedge clk);
        drive(OP_ADD, 32'd1, 32'd2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            nvec++;
            if (ir !== 1'b0 || ov !== 1'b1 || res !== 32'd30) begin
                nfail++;
                $display("FAIL bp_hold[%0d]: got r%b v%b %0d exp r0 v1 30",
                         i, ir, ov, res);
            end
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b1 || res !== 32'd3) begin
            nfail++;
            $display("FAIL bp_second: got v%b %0d exp v1 3", ov, res);
        end
        @(negedge clk);
        iv = 1'b0;
        @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b0) begin
            nfail++;
            $display("FAIL bp_drain: got v%b exp v0", ov);
        end
    endtask

    task automatic test_undef();
        @(negedge clk);
        drive(OP_ADD, 32'd7, 32'd8);
        @(posedge clk);
        @(negedge clk);
        drive(4'b1111, 32'h5, 32'h5);
        @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b1 || res !== 32'h0 || ovf !== 1'b0 || zr !== 1'b0) begin
            nfail++;
            $display("FAIL undef: got v%b %h o%b z%b exp v1 0 o0 z0",
                     ov, res, ovf, zr);
        end
        @(negedge clk);
        iv = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        @(negedge clk);
        drive(OP_ADD, 32'd7, 32'd8);
        @(posedge clk);
        #1;
        nvec++;
        if (res !== 32'd15) begin
            nfail++;
            $display("FAIL rst_pre: got %0d exp 15", res);
        end
        @(negedge clk);
        drive(OP_MULU, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        iv = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        nvec++;
        if (bsy !== 1'b1) begin
            nfail++;
            $display("FAIL rst_busy: got %b exp 1", bsy);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({ov, ovf, zr, bsy, ir} !== 5'b0 || res !== 32'h0) begin
            nfail++;
            $display("FAIL rst_mid: got v%b o%b z%b b%b r%b %h exp all 0",
                     ov, ovf, zr, bsy, ir, res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nvec++;
        if (ir !== 1'b1 || bsy !== 1'b0) begin
            nfail++;
            $display("FAIL rst_release: got r%b b%b exp r1 b0", ir, bsy);
        end
        @(negedge clk);
        drive(OP_ADD, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b1 || res !== 32'd5) begin
            nfail++;
            $display("FAIL rst_add: got v%b %0d exp v1 5", ov, res);
        end
        @(negedge clk);
        iv = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        nvec++;
        if (ov !== 1'b0 || res !== 32'd5) begin
            nfail++;
            $display("FAIL rst_nomul: got v%b %0d exp v0 5", ov, res);
        end
    endtask

    task automatic test_w16();
        logic [3:0]  op [5];
        logic [15:0] x [5];
        logic [15:0] y [5];
        logic [15:0] r [5];
        logic        o [5];
        logic        z [5];
        int          lat;
        op[0] = OP_ADD;  x[0] = 16'hFFFF; y[0] = 16'h1;
        r[0] = 16'h0; o[0] = 1'b0; z[0] = 1'b1;
        op[1] = OP_ADDS; x[1] = 16'h7FFF; y[1] = 16'h1;
        r[1] = 16'h8000; o[1] = 1'b1; z[1] = 1'b0;
        op[2] = OP_SUBS; x[2] = 16'h8000; y[2] = 16'h1;
        r[2] = 16'h7FFF; o[2] = 1'b1; z[2] = 1'b0;
        op[3] = OP_SLT;  x[3] = 16'hFFFF; y[3] = 16'h1;
        r[3] = 16'h1; o[3] = 1'b0; z[3] = 1'b0;
        op[4] = OP_SRA;  x[4] = 16'h8000; y[4] = 16'h11;
        r[4] = 16'hC000; o[4] = 1'b0; z[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ctl16 = op[i];
            a16   = x[i];
            b16   = y[i];
            iv16  = 1'b1;
            @(posedge clk);
            #1;
            nvec++;
            if (ov16 !== 1'b1 || res16 !== r[i] ||
                ovf16 !== o[i] || zr16 !== z[i]) begin
                nfail++;
                $display("FAIL w16[%0d]: got v%b %h o%b z%b exp v1 %h o%b z%b",
                         i, ov16, res16, ovf16, zr16, r[i], o[i], z[i]);
            end
        end
        @(negedge clk);
        ctl16 = OP_MULU;
        a16   = 16'd300;
        b16   = 16'd200;
        @(posedge clk);
        #1;
        iv16 = 1'b0;
        lat  = 0;
        while (ov16 !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        nvec++;
        if (lat != 17 || res16 !== 16'd60000 || ovf16 !== 1'b0) begin
            nfail++;
            $display("FAIL w16_mul: got lat %0d %0d o%b exp lat 17 60000 o0",
                     lat, res16, ovf16);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shifts();
        test_mulu();
        test_backpressure();
        test_undef();
        test_reset_mid_mul();
        test_w16();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
